fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised RV32I fetch front-end replacing the single-register PC stage.
//  - Owns the PC and issues in-order requests to instruction memory over a req/gnt + rvalid bus.
//  - Buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode.
//  - Redirects (branch/jump/trap) flush the queue and discard in-flight responses.
// PARAMETERS
//  XLEN      32       datapath/address width (= rv32i_pkg::DPW)
//  DEPTH     4        instruction queue entries; also max outstanding+buffered (power of 2, >=2)
//  RESET_PC  32'h0    PC loaded on reset
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  redirect_i     in   1     redirect/flush request from execute
//  redirect_pc_i  in   XLEN  new fetch address (bits[1:0] ignored, forced 0)
//  imem_req_o     out  1     fetch request valid
//  imem_addr_o    out  XLEN  fetch address (= pc_q)
//  imem_gnt_i     in   1     request accepted this cycle (when imem_req_o=1)
//  imem_rvalid_i  in   1     response valid, in request order, >=1 cycle after gnt
//  imem_rdata_i   in   32    instruction word
//  instr_valid_o  out  1     queue head valid
//  instr_o        out  32    queue head instruction
//  instr_pc_o     out  XLEN  queue head PC
//  instr_ready_i  in   1     decode accepts head (0 = stall)
// BEHAVIOUR
//  - Reset (async assert, sync use after deassert): pc_q=RESET_PC, queue empty, outstanding=0,
//    discard=0; imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0 (perf counters 0).
//  - Credits: imem_req_o = !redirect_i && (occupancy + outstanding < DEPTH). Combinational; no
//    hold requirement; a withdrawn ungranted request has no effect.
//  - Grant (req&gnt): pc_q += 4 (wraps mod 2^XLEN); PC of request pushed into pending-PC slot
//    at tail; outstanding++.
//  - Response (rvalid): if discard>0 -> drop, discard--; else write rdata into oldest pending
//    slot, mark valid, outstanding--. Response with no outstanding/discard = protocol error
//    (assertion), ignored.
//  - Dequeue: instr_valid_o&instr_ready_i pops head. Head ordered; min latency gnt->instr_valid_o
//    = rvalid cycle +1 (registered queue, no bypass). Full throughput 1 instr/cycle when gnt
//    and rvalid stream.
//  - Simultaneous push+pop when full allowed; occupancy unchanged.
//  - Redirect (priority over all): next cycle pc_q=redirect_pc_i&~3, queue emptied,
//    discard += outstanding (+1 if a grant occurs this cycle... cannot: req masked), rvalid
//    arriving in redirect cycle is dropped against the pre-redirect accounting; outstanding=0.
//    instr_valid_o=0 the cycle after redirect.
//  - Back-to-back redirects: last one wins; discard accumulates, saturates at DEPTH (cannot
//    exceed by construction).
//  - Stall (instr_ready_i=0) freezes head; fetch continues until credits exhausted.
//  - FSM (2 states): RUN (discard==0) / DRAIN (discard>0); requests allowed in both,
//    responses dropped only in DRAIN.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt_o[31:0] (cycles instr_valid_o&!ready)
//    and perf_flush_cnt_o[31:0] (redirects); saturating, reset 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  rv32i_pkg: DPW, RESET_PC default, typedef fq_entry_t {logic vld; logic [31:0] instr;
//    logic [DPW-1:0] pc;}.
//  Sub-module fq_ring_buffer (DEPTH entries, alloc-at-grant / fill-at-rvalid / pop-at-head
//    pointers).
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle later, ready=1 -> addrs 0,4,8..; instr_pc_o 0,4,8 one per cycle.
//  2 ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants then imem_req_o=0; release -> 4 in order.
//  3 2 outstanding, redirect_pc_i=0x100 -> 2 responses dropped; next instr_pc_o=0x100.
//  4 redirect and rvalid same cycle, then redirect_pc_i=0x203 -> response dropped; fetch 0x200.
//  5 pc_q=0xFFFFFFFC grant -> next addr 0x0.
//  6 rst_n low mid-stream with 3 outstanding -> all outputs reset immediately; late rvalids
//    flagged by assertion.
//  FETCH_PERF_EN: scenario 2 -> perf_stall_cnt_o=10; scenario 3 -> perf_flush_cnt_o=1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: datapath width, default reset PC, fetch queue entry and drain FSM states.
package rv32i_pkg;
  localparam int DPW = 32;
  localparam logic [DPW-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic           vld;
    logic [31:0]    instr;
    logic [DPW-1:0] pc;
  } fq_entry_t;

  typedef enum logic {FQ_RUN, FQ_DRAIN} fq_state_e;
endpackage

// File: rtl/fq_ring_buffer.sv
// Fetch queue storage: slot allocated at grant (PC), filled at rvalid (instr), popped at head.
module fq_ring_buffer
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [DPW-1:0]           alloc_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_data,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   used,
  output logic [$clog2(DEPTH):0]   pend
);
  localparam int AW = $clog2(DEPTH);

  fq_entry_t     ent [DEPTH];
  logic [AW:0]   head_p, fill_p, tail_p;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign used = tail_p - head_p;
  assign pend = tail_p - fill_p;
  assign head = ent[head_p[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p <= '0;
      fill_p <= '0;
      tail_p <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      head_p <= '0;
      fill_p <= '0;
      tail_p <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
    end else begin
      if (alloc) begin
        ent[tail_p[AW-1:0]].pc  <= alloc_pc;
        ent[tail_p[AW-1:0]].vld <= 1'b0;
        tail_p <= tail_p + 1'b1;
      end
      if (fill) begin
        ent[fill_p[AW-1:0]].instr <= fill_data;
        ent[fill_p[AW-1:0]].vld   <= 1'b1;
        fill_p <= fill_p + 1'b1;
      end
      if (pop) begin
        ent[head_p[AW-1:0]].vld <= 1'b0;
        head_p <= head_p + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// RV32I fetch front-end: PC, credit-limited imem requests, in-order instruction queue, redirect drain.
// Optional FETCH_PERF_EN adds saturating stall/flush performance counters.
module fetch_queue_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = DPW,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_flush_cnt_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   used, pend, discard_q, discard_d;
  logic [CW:0]     inflight, tot;
  fq_state_e       state_q, state_d;
  fq_entry_t       head;
  logic            grant, fill, pop;

  // Dropped-but-pending responses still hold credits, keeping every in-flight response bounded by DEPTH.
  assign inflight    = {1'b0, used} + {1'b0, discard_q};
  assign imem_req_o  = rst_n && !redirect_i && (inflight < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign fill        = imem_rvalid_i && !redirect_i && (state_q == FQ_RUN) && (pend != '0);
  assign pop         = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = head.vld;
  assign instr_o       = head.vld ? head.instr : '0;
  assign instr_pc_o    = head.vld ? head.pc    : '0;

  fq_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .alloc     (grant),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_data (imem_rdata_i),
    .pop       (pop),
    .head      (head),
    .used      (used),
    .pend      (pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      state_q   <= FQ_RUN;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (redirect_i)  pc_q <= redirect_pc_i & ~XLEN'(3);
      else if (grant)  pc_q <= pc_q + XLEN'(4);
    end
  end

  // A response landing in the redirect cycle is charged against the pre-redirect accounting.
  always_comb begin
    discard_d = discard_q;
    state_d   = state_q;
    tot       = {1'b0, discard_q} + {1'b0, pend};
    if (redirect_i) begin
      if (imem_rvalid_i && tot != '0) tot = tot - (CW+1)'(1);
      discard_d = (tot > (CW+1)'(DEPTH)) ? CW'(DEPTH) : tot[CW-1:0];
    end else begin
      unique case (state_q)
        FQ_RUN:   ;
        FQ_DRAIN: if (imem_rvalid_i) discard_d = discard_q - CW'(1);
      endcase
    end
    state_d = (discard_d != '0) ? FQ_DRAIN : FQ_RUN;
  end

  rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (pend != '0 || discard_q != '0));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (instr_valid_o && !instr_ready_i && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (redirect_i && perf_flush_cnt_o != '1)
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`endif
endmodule
